// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams big-endian instruction words
// into instruction memory and holds the CPU PC in reset until the program
// is fully written.
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to append a 4-byte checksum
// word after the program. The load then only releases the CPU when the
// checksum matches.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, CPU held in reset
// LOAD  | accepting program bytes, one memory write per 4 bytes
// CHECK | accepting the 4-byte checksum word (checksum build only)
// DONE  | program written, CPU released, fetch starts at word 0
// ERR   | checksum mismatch, CPU held in reset (checksum build only)
module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [31:0]       imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;
   // The checksum word always follows the program, even an empty one.
   localparam state_t AFTER_LOAD = CHECK;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      DONE  = 3'd3
   } state_t;
   localparam state_t AFTER_LOAD = DONE;
`endif

   state_t            state;
   state_t            state_nx;

   logic [ADDR_W:0]   count_clamp;
   logic [ADDR_W:0]   word_total;
   logic [ADDR_W:0]   ptr;
   logic [ADDR_W:0]   ptr_inc;
   logic [1:0]        byte_cnt;
   logic [23:0]       shift;
   logic [31:0]       assembled;

   logic              xfer;
   logic              last_byte;
   logic              last_word;
   logic              start_ok;
   logic              done_nx;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]       csum;
   logic              error_q;
   logic              error_nx;
`endif

   // Program length is clamped so writes never run past the memory.
   assign count_clamp = (word_count > DEPTH_W) ? DEPTH_W : word_count;

   assign ptr_inc     = ptr + ONE_W;
   assign last_word   = (ptr_inc == word_total);
   assign assembled   = {shift, byte_data};

   // Ready depends only on state so the source sees a stable handshake.
   always_comb begin
      byte_ready = (state == LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == CHECK) begin
         byte_ready = 1'b1;
      end
`endif
   end

   assign busy      = byte_ready;
   assign xfer      = byte_valid & byte_ready;
   assign last_byte = xfer && (byte_cnt == 2'd3);

   // State register.
   always_ff @(posedge clock) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and registered-status targets.
   always_comb begin
      state_nx = state;
      start_ok = 1'b0;
      done_nx  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      error_nx = 1'b0;
`endif

      case (state)
         LOAD: begin
            if (last_byte && last_word) begin
               state_nx = AFTER_LOAD;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (last_byte) begin
               state_nx = (assembled == csum) ? DONE : ERR;
            end
         end
         ERR: begin
            error_nx = 1'b1;
         end
`endif
         DONE: begin
            done_nx = 1'b1;
         end
         default: begin
         end
      endcase

      // start is only honoured while no byte stream is in progress; it
      // drops done/error and re-asserts cpu_reset on the accepting edge.
      if (start && !byte_ready) begin
         start_ok = 1'b1;
         done_nx  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         error_nx = 1'b0;
`endif
         state_nx = (count_clamp == '0) ? AFTER_LOAD : LOAD;
      end
   end

   // Byte assembly, memory write strobe and status registers.
   always_ff @(posedge clock) begin
      if (rst) begin
         word_total <= '0;
         ptr        <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         done       <= 1'b0;
         cpu_reset  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum       <= '0;
         error_q    <= 1'b0;
`endif
      end else begin
         imem_we   <= 1'b0;
         done      <= done_nx;
         cpu_reset <= ~done_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
         error_q   <= error_nx;
`endif
         if (start_ok) begin
            word_total <= count_clamp;
            ptr        <= '0;
            byte_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
         end else if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], byte_data};
            if ((state == LOAD) && (byte_cnt == 2'd3)) begin
               imem_we    <= 1'b1;
               imem_addr  <= 32'(ptr[ADDR_W-1:0]);
               imem_wdata <= assembled;
               ptr        <= ptr_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum       <= csum + assembled;
`endif
            end
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as the
// program is streamed and compared when imem_we pulses.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clock;
   logic        rst;
   logic        start;
   logic [8:0]  word_count;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   logic [63:0] exp_q[$];
   int          we_cyc[$];
   logic [31:0] last_we_addr = '0;
   logic [63:0] mon_e;
   logic [31:0] prog[$];

   imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
      .clock      (clock),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest queued expectation.
   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         we_cyc.push_back(cyc);
         last_we_addr = imem_addr;
         if (exp_q.size() == 0) begin
            chk("we_unexpected", 32'(imem_we), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("we_addr", imem_addr, mon_e[63:32]);
            chk("we_data", imem_wdata, mon_e[31:0]);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      waited = 0;
      byte_valid = 1'b0;
      repeat (gap) begin
         @(negedge clock);
         chk("busy_stall", 32'(busy), 32'd1);
         @(posedge clock);
         #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clock);
      while (!byte_ready && waited < 50) begin
         waited++;
         @(negedge clock);
      end
      if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
      @(posedge clock);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send_byte(w[31:24], gap);
      send_byte(w[23:16], gap);
      send_byte(w[15:8],  gap);
      send_byte(w[7:0],   gap);
   endtask

   task automatic load(input int wc, input int gap, input logic [31:0] csum_add);
      int n;
      logic [31:0] sum;
      n   = (wc > 256) ? 256 : wc;
      sum = '0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({32'(i), prog[i]});
         sum = sum + prog[i];
      end
      start      = 1'b1;
      word_count = 9'(wc);
      @(posedge clock);
      #1;
      start = 1'b0;
      chk("start_done_clr", 32'(done), 32'd0);
      chk("start_cpu_rst", 32'(cpu_reset), 32'd1);
      chk("start_err_clr", 32'(error), 32'd0);
      for (int i = 0; i < n; i++) send_word(prog[i], gap);
      if (CSUM_EN) send_word(sum + csum_add, gap);
   endtask

   task automatic release_ok(input bit last_we);
      @(negedge clock);
      chk("rel_done_early", 32'(done), 32'd0);
      chk("rel_cpu_rst_early", 32'(cpu_reset), 32'd1);
      chk("rel_last_we", 32'(imem_we), 32'(last_we && !CSUM_EN));
      @(negedge clock);
      chk("rel_done", 32'(done), 32'd1);
      chk("rel_cpu_rst", 32'(cpu_reset), 32'd0);
      chk("rel_busy", 32'(busy), 32'd0);
      chk("rel_error", 32'(error), 32'd0);
      chk("rel_we_off", 32'(imem_we), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      @(posedge clock);
      #1;
      rst = 1'b0;

      // Basic two-word load, valid held high.
      prog = '{32'h20010005, 32'h8C220004};
      we_cyc.delete();
      load(2, 0, 32'd0);
      release_ok(1'b1);
      chk("basic_we_count", 32'(we_cyc.size()), 32'd2);
      if (we_cyc.size() == 2) chk("basic_we_spacing", 32'(we_cyc[1] - we_cyc[0]), 32'd4);

      // Same program from a source that stalls 3 cycles before each byte.
      we_cyc.delete();
      load(2, 3, 32'd0);
      release_ok(1'b1);
      chk("stall_we_count", 32'(we_cyc.size()), 32'd2);

      // Empty program.
      we_cyc.delete();
      load(0, 0, 32'd0);
      release_ok(1'b0);
      chk("zero_we_count", 32'(we_cyc.size()), 32'd0);

      // Oversize count clamps to the memory depth.
      prog.delete();
      for (int i = 0; i < 256; i++) prog.push_back({8'hA5, 8'(i), 16'(i * 3 + 7)});
      we_cyc.delete();
      load(300, 0, 32'd0);
      release_ok(1'b1);
      chk("over_we_count", 32'(we_cyc.size()), 32'd256);
      chk("over_last_addr", last_we_addr, 32'd255);

      // Reset after 6 bytes of a 3-word load.
      exp_q.push_back({32'd0, 32'h11223344});
      start      = 1'b1;
      word_count = 9'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      send_word(32'h11223344, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      rst = 1'b1;
      @(posedge clock);
      #1;
      rst = 1'b0;
      @(negedge clock);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(byte_ready), 32'd0);
      chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("midrst_we", 32'(imem_we), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      prog = '{32'hDEADBEEF};
      load(1, 0, 32'd0);
      release_ok(1'b1);

      // Restart from DONE rewrites word 0.
      prog = '{32'hCAFEF00D};
      load(1, 0, 32'd0);
      release_ok(1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Words sum to zero modulo 2^32.
      prog = '{32'h00000001, 32'hFFFFFFFF};
      load(2, 0, 32'd0);
      release_ok(1'b1);

      // Wrong checksum holds the CPU in reset.
      load(2, 0, 32'd1);
      @(negedge clock);
      chk("csum_err_early", 32'(error), 32'd0);
      @(negedge clock);
      chk("csum_err", 32'(error), 32'd1);
      chk("csum_err_cpu_rst", 32'(cpu_reset), 32'd1);
      chk("csum_err_done", 32'(done), 32'd0);
      repeat (3) @(negedge clock);
      chk("csum_err_hold", 32'(cpu_reset), 32'd1);

      // Recovery from ERR.
      @(posedge clock);
      #1;
      prog = '{32'h12345678};
      load(1, 0, 32'd0);
      release_ok(1'b1);
`endif

      repeat (2) @(negedge clock);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
